// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage and its lane-alignment helper.
//   XLEN_DEF   : default datapath/address width
//   mem_size_e : load/store access size encoding (byte/half/word/double)
//   state_e    : memory-stage FSM states
package mem_stage_pkg;

  localparam int unsigned XLEN_DEF = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_WB
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for an 8-byte-wide data memory.
//   size        : access size (mem_size_e encoding)
//   off         : byte offset within the 8-byte word (addr[2:0])
//   is_unsigned : zero-extend instead of sign-extend loads
//   store_data  : unshifted store value
//   rdata       : raw 8-byte-aligned read data
//   wmask       : byte-enable mask for a store
//   wdata       : store data shifted into its byte lanes
//   ldata       : load data shifted down and extended to XLEN
//   misaligned  : offset is not a multiple of the access size
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [1:0]      size,
  input  logic [2:0]      off,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [7:0]      wmask,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ldata,
  output logic            misaligned
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] raw;
  logic            sext;

  assign shamt = {off, 3'b000};
  assign raw   = rdata >> shamt;
  assign wdata = store_data << shamt;
  assign sext  = ~is_unsigned;

  always_comb begin
    wmask      = '0;
    ldata      = '0;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        wmask = 8'h01 << off;
        ldata = {{(XLEN-8){sext & raw[7]}}, raw[7:0]};
      end
      SZ_H: begin
        wmask      = 8'h03 << off;
        ldata      = {{(XLEN-16){sext & raw[15]}}, raw[15:0]};
        misaligned = off[0];
      end
      SZ_W: begin
        wmask      = 8'h0F << off;
        ldata      = {{(XLEN-32){sext & raw[31]}}, raw[31:0]};
        misaligned = |off[1:0];
      end
      SZ_D: begin
        wmask      = 8'hFF << off;
        ldata      = raw;
        misaligned = |off;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: accepts one execute result, performs at most
// one load/store over a valid/ready data-memory port, then presents one
// registered result to write-back.
//   clk, rst                 : clock, asynchronous active-low reset
//   in_valid / in_ready      : execute-result handshake
//   alu_result .. rf_wen     : captured execute-stage fields
//   dm_req_*, dm_addr, dm_wen, dm_wdata, dm_wmask : memory request channel
//   dm_rsp_valid, dm_rdata   : memory response channel
//   wb_valid / wb_ready      : write-back handshake
//   wb_data, wb_rd, wb_wen   : write-back result
//   mem_fault                : misaligned access or response timeout
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] ram_addr,
  input  logic [XLEN-1:0] store_data,
  input  logic            mem_rd,
  input  logic            mem_wr,
  input  logic [1:0]      mem_size,
  input  logic            mem_unsigned,
  input  logic [4:0]      rd,
  input  logic            rf_wen,
  output logic            dm_req_valid,
  input  logic            dm_req_ready,
  output logic [XLEN-1:0] dm_addr,
  output logic            dm_wen,
  output logic [XLEN-1:0] dm_wdata,
  output logic [7:0]      dm_wmask,
  input  logic            dm_rsp_valid,
  input  logic [XLEN-1:0] dm_rdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_wen,
  output logic            mem_fault
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            capture;

  logic [XLEN-1:0] alu_q, addr_q, sd_q;
  logic [1:0]      size_q;
  logic            uns_q, rfw_q, ld_q, wr_q;
  logic [4:0]      rd_q;

  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_wen_q, wb_wen_d;
  logic            fault_q, fault_d;

  logic [1:0]      al_size;
  logic [2:0]      al_off;
  logic            al_uns;
  logic [XLEN-1:0] al_sd;
  logic [7:0]      al_wmask;
  logic [XLEN-1:0] al_wdata, al_ldata;
  logic            al_mis;

  // One aligner serves both phases: in IDLE it sees the live inputs so the
  // misalignment decision is made at accept; afterwards it sees the captured
  // instruction for request lanes and load extension.
  assign al_size = (state == S_IDLE) ? mem_size           : size_q;
  assign al_off  = (state == S_IDLE) ? ram_addr[2:0]      : addr_q[2:0];
  assign al_uns  = (state == S_IDLE) ? mem_unsigned       : uns_q;
  assign al_sd   = (state == S_IDLE) ? store_data         : sd_q;

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .size        (al_size),
    .off         (al_off),
    .is_unsigned (al_uns),
    .store_data  (al_sd),
    .rdata       (dm_rdata),
    .wmask       (al_wmask),
    .wdata       (al_wdata),
    .ldata       (al_ldata),
    .misaligned  (al_mis)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    capture   = 1'b0;
    wb_data_d = wb_data_q;
    wb_wen_d  = wb_wen_q;
    fault_d   = fault_q;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          if (!mem_rd && !mem_wr) begin
            wb_data_d = alu_result;
            wb_wen_d  = rf_wen;
            fault_d   = 1'b0;
            state_d   = S_WB;
          end else if (al_mis) begin
            wb_data_d = ram_addr;
            wb_wen_d  = 1'b0;
            fault_d   = 1'b1;
            state_d   = S_WB;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dm_req_ready) begin
          cnt_d   = '0;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (dm_rsp_valid) begin
          wb_data_d = ld_q ? al_ldata : alu_q;
          wb_wen_d  = ld_q & rfw_q;
          fault_d   = 1'b0;
          state_d   = S_WB;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          wb_data_d = addr_q;
          wb_wen_d  = 1'b0;
          fault_d   = 1'b1;
          state_d   = S_WB;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_WB: begin
        if (wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q     <= '0;
      addr_q    <= '0;
      sd_q      <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      rd_q      <= '0;
      rfw_q     <= 1'b0;
      ld_q      <= 1'b0;
      wr_q      <= 1'b0;
      wb_data_q <= '0;
      wb_wen_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      if (capture) begin
        alu_q  <= alu_result;
        addr_q <= ram_addr;
        sd_q   <= store_data;
        size_q <= mem_size;
        uns_q  <= mem_unsigned;
        rd_q   <= rd;
        rfw_q  <= rf_wen;
        ld_q   <= mem_rd;
        wr_q   <= mem_wr;
      end
      wb_data_q <= wb_data_d;
      wb_wen_q  <= wb_wen_d;
      fault_q   <= fault_d;
    end
  end

  // Gated by rst so the stage never advertises readiness while held in reset.
  assign in_ready     = rst && (state == S_IDLE);
  assign dm_req_valid = (state == S_REQ);
  assign dm_addr      = dm_req_valid ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign dm_wen       = dm_req_valid & wr_q;
  assign dm_wmask     = dm_wen ? al_wmask : '0;
  assign dm_wdata     = dm_wen ? al_wdata : '0;

  assign wb_valid  = (state == S_WB);
  assign wb_data   = wb_data_q;
  assign wb_rd     = rd_q;
  assign wb_wen    = wb_wen_q;
  assign mem_fault = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [63:0] alu_result, ram_addr, store_data;
  logic        mem_rd, mem_wr;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [4:0]  rd;
  logic        rf_wen;
  logic        dm_req_valid, dm_req_ready;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_wen;
  logic [7:0]  dm_wmask;
  logic        dm_rsp_valid;
  logic        wb_valid, wb_ready;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_wen, mem_fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(64), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .ram_addr(ram_addr), .store_data(store_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .rd(rd), .rf_wen(rf_wen),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
    .dm_addr(dm_addr), .dm_wen(dm_wen), .dm_wdata(dm_wdata), .dm_wmask(dm_wmask),
    .dm_rsp_valid(dm_rsp_valid), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_wen(wb_wen), .mem_fault(mem_fault)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: select the addressed bytes, then extend per signedness.
  function automatic logic [63:0] exp_load(input logic [63:0] raw, input logic [63:0] addr,
                                           input logic [1:0] sz, input logic uns);
    int n;
    logic [63:0] v, m;
    n = 1 << sz;
    v = raw >> (8 * addr[2:0]);
    if (n < 8) begin
      m = (64'd1 << (8 * n)) - 64'd1;
      v = v & m;
      if (!uns && v[8*n-1]) v = v | ~m;
    end
    return v;
  endfunction

  task automatic scramble_inputs;
    alu_result   = {$urandom, $urandom};
    ram_addr     = {$urandom, $urandom};
    store_data   = {$urandom, $urandom};
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = 2'($urandom);
    mem_unsigned = 1'($urandom);
    rd           = 5'($urandom);
    rf_wen       = 1'($urandom);
  endtask

  task automatic run_op(input string nm, input logic [63:0] a_alu, input logic [63:0] a_addr,
                        input logic [63:0] a_sd, input logic a_rd, input logic a_wr,
                        input logic [1:0] a_sz, input logic a_uns, input logic [4:0] a_rdn,
                        input logic a_wen, input logic [63:0] a_rdata, input int rq_in,
                        input int rs_in, input int hold, input bit no_rsp);
    int n, lat, e_lat, waitc, rq, rs;
    bit mem, mis, req_seen, phase, done, chk_data;
    logic [63:0] e_data, e_wd;
    logic        e_wen, e_fault;
    logic [7:0]  e_mask;

    rq = rq_in;
    rs = rs_in;
    n    = 1 << a_sz;
    mem  = a_rd | a_wr;
    mis  = mem && ((a_addr % 64'(n)) != 0);
    e_mask = a_wr ? 8'(((1 << n) - 1) << a_addr[2:0]) : 8'h00;
    e_wd   = a_wr ? (a_sd << (8 * a_addr[2:0])) : 64'd0;
    chk_data = 1'b1;
    if (!mem) begin
      e_data = a_alu; e_wen = a_wen; e_fault = 1'b0; e_lat = 1;
    end else if (mis) begin
      e_data = a_addr; e_wen = 1'b0; e_fault = 1'b1; e_lat = 1;
    end else if (no_rsp) begin
      e_data = '0; chk_data = 1'b0; e_wen = 1'b0; e_fault = 1'b1; e_lat = 2 + rq + TO;
    end else if (a_rd) begin
      e_data = exp_load(a_rdata, a_addr, a_sz, a_uns); e_wen = a_wen; e_fault = 1'b0;
      e_lat = 3 + rq + rs;
    end else begin
      e_data = a_alu; e_wen = 1'b0; e_fault = 1'b0; e_lat = 3 + rq + rs;
    end

    waitc = 0;
    while (!in_ready && waitc < 20) begin
      tick;
      waitc++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s accept: in_ready=%b required 1", nm, in_ready);
    end

    alu_result = a_alu; ram_addr = a_addr; store_data = a_sd;
    mem_rd = a_rd; mem_wr = a_wr; mem_size = a_sz; mem_unsigned = a_uns;
    rd = a_rdn; rf_wen = a_wen;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    scramble_inputs();

    lat = 1; phase = 0; req_seen = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      dm_req_ready = 1'b0;
      dm_rsp_valid = 1'b0;
      dm_rdata     = {$urandom, $urandom};
      if (wb_valid) begin
        done = 1;
      end else begin
        if (dm_req_valid) begin
          req_seen = 1;
          total++;
          if (!mem || mis || dm_addr !== {a_addr[63:3], 3'b000} || dm_wen !== a_wr ||
              dm_wmask !== e_mask || dm_wdata !== e_wd) begin
            bad++;
            $display("FAIL %s request: addr=%h wen=%b mask=%h wdata=%h required addr=%h wen=%b mask=%h wdata=%h (mem=%0b mis=%0b)",
                     nm, dm_addr, dm_wen, dm_wmask, dm_wdata, {a_addr[63:3], 3'b000}, a_wr,
                     e_mask, e_wd, mem, mis);
          end
          if (rq == 0) begin
            dm_req_ready = 1'b1;
            phase = 1;
          end else rq--;
        end else if (phase) begin
          if (!no_rsp && rs == 0) begin
            dm_rsp_valid = 1'b1;
            dm_rdata     = a_rdata;
          end else if (rs > 0) rs--;
        end
        tick;
        lat++;
      end
    end
    dm_req_ready = 1'b0;
    dm_rsp_valid = 1'b0;

    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s wb_valid: never seen within budget, required 1", nm);
      return;
    end
    total++;
    if (mem && !mis && !req_seen) begin
      bad++;
      $display("FAIL %s request: dm_req_valid never seen, required 1", nm);
    end
    total++;
    if (lat != e_lat) begin
      bad++;
      $display("FAIL %s latency: got=%0d required=%0d", nm, lat, e_lat);
    end
    total++;
    if ((chk_data && wb_data !== e_data) || wb_wen !== e_wen || mem_fault !== e_fault ||
        wb_rd !== a_rdn) begin
      bad++;
      $display("FAIL %s result: data=%h wen=%b fault=%b rd=%0d required data=%h wen=%b fault=%b rd=%0d",
               nm, wb_data, wb_wen, mem_fault, wb_rd, e_data, e_wen, e_fault, a_rdn);
    end

    wb_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      dm_rsp_valid = 1'($urandom);
      tick;
      total++;
      if (wb_valid !== 1'b1 || in_ready !== 1'b0 || (chk_data && wb_data !== e_data) ||
          mem_fault !== e_fault || wb_wen !== e_wen) begin
        bad++;
        $display("FAIL %s hold%0d: valid=%b in_ready=%b data=%h fault=%b required valid=1 in_ready=0 data=%h fault=%b",
                 nm, h, wb_valid, in_ready, wb_data, mem_fault, e_data, e_fault);
      end
    end
    dm_rsp_valid = 1'b0;
    wb_ready = 1'b1;
    tick;
    wb_ready = 1'b0;
    total++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s release: wb_valid=%b in_ready=%b required 0 and 1", nm, wb_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    in_valid = 1'b0; dm_req_ready = 1'b0; dm_rsp_valid = 1'b0; dm_rdata = '0; wb_ready = 1'b0;
    scramble_inputs();
    #3;
    total++;
    if (in_ready !== 1'b0 || dm_req_valid !== 1'b0 || wb_valid !== 1'b0 || mem_fault !== 1'b0 ||
        wb_data !== 64'd0 || wb_wen !== 1'b0 || dm_wen !== 1'b0 || dm_addr !== 64'd0) begin
      bad++;
      $display("FAIL reset outputs: in_ready=%b req=%b wb_valid=%b fault=%b wb_data=%h required all 0",
               in_ready, dm_req_valid, wb_valid, mem_fault, wb_data);
    end
    tick;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset in_ready held: got=%b required 0", in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    tick;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset release in_ready: got=%b required 1", in_ready);
    end
  endtask

  task automatic test_store_byte;
    run_op("st_byte", 64'h77, 64'h8000_0003, 64'hAB, 1'b0, 1'b1, 2'b00, 1'b0, 5'd3, 1'b1,
           64'd0, 0, 0, 0, 1'b0);
    run_op("st_dword_stall", 64'h55, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, 2'b11,
           1'b0, 5'd4, 1'b1, 64'd0, 3, 2, 1, 1'b0);
  endtask

  task automatic test_load_half;
    run_op("ld_half_s", 64'h1, 64'h8000_0006, 64'd0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd7, 1'b1,
           64'h8001_0000_0000_0000, 0, 0, 0, 1'b0);
    run_op("ld_half_u", 64'h1, 64'h8000_0006, 64'd0, 1'b1, 1'b0, 2'b01, 1'b1, 5'd8, 1'b1,
           64'h8001_0000_0000_0000, 0, 0, 0, 1'b0);
  endtask

  task automatic test_misaligned;
    run_op("ld_word_mis", 64'h9, 64'h8000_0002, 64'd0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd9, 1'b1,
           64'd0, 0, 0, 0, 1'b0);
    run_op("st_dword_mis", 64'h9, 64'h8000_0004, 64'hFF, 1'b0, 1'b1, 2'b11, 1'b0, 5'd10, 1'b1,
           64'd0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_passthrough_hold;
    run_op("pass_hold", 64'h1234, 64'h0, 64'h0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd5, 1'b1,
           64'd0, 0, 0, 4, 1'b0);
  endtask

  task automatic test_timeout;
    run_op("timeout", 64'h42, 64'h8000_0010, 64'd0, 1'b1, 1'b0, 2'b11, 1'b0, 5'd11, 1'b1,
           64'd0, 0, 0, 0, 1'b1);
    dm_rsp_valid = 1'b1;
    dm_rdata     = 64'hDEAD_BEEF_DEAD_BEEF;
    tick;
    dm_rsp_valid = 1'b0;
    total++;
    if (wb_valid !== 1'b0 || dm_req_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL late_rsp: wb_valid=%b req=%b in_ready=%b required 0 0 1",
               wb_valid, dm_req_valid, in_ready);
    end
    run_op("timeout_stall", 64'h43, 64'h8000_0020, 64'h77, 1'b0, 1'b1, 2'b10, 1'b0, 5'd12, 1'b0,
           64'd0, 2, 0, 0, 1'b1);
  endtask

  task automatic test_reset_midop;
    ram_addr = 64'h8000_0040; mem_rd = 1'b1; mem_wr = 1'b0; mem_size = 2'b11;
    mem_unsigned = 1'b0; rd = 5'd13; rf_wen = 1'b1; alu_result = 64'h5;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    dm_req_ready = 1'b1;
    tick;
    dm_req_ready = 1'b0;
    tick;
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b0 || dm_req_valid !== 1'b0 || dm_addr !== 64'd0 || dm_wen !== 1'b0 ||
        dm_wmask !== 8'd0 || dm_wdata !== 64'd0 || wb_valid !== 1'b0 || wb_data !== 64'd0 ||
        wb_wen !== 1'b0 || wb_rd !== 5'd0 || mem_fault !== 1'b0) begin
      bad++;
      $display("FAIL reset_midop: in_ready=%b req=%b addr=%h wb_valid=%b wb_data=%h rd=%0d fault=%b required all 0",
               in_ready, dm_req_valid, dm_addr, wb_valid, wb_data, wb_rd, mem_fault);
    end
    @(negedge clk);
    rst = 1'b1;
    tick;
    run_op("after_reset", 64'h0, 64'h8000_0048, 64'd0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd14, 1'b1,
           64'h1122_3344_F566_7788, 0, 1, 0, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_op("b2b_0", 64'hA0, 64'h0, 64'h0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd1, 1'b1, 64'd0, 0, 0, 0, 1'b0);
    run_op("b2b_1", 64'hA1, 64'h0, 64'h0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd2, 1'b0, 64'd0, 0, 0, 0, 1'b0);
    run_op("b2b_2", 64'hA2, 64'h100, 64'hBEEF, 1'b0, 1'b1, 2'b01, 1'b0, 5'd3, 1'b1, 64'd0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_random;
    logic [63:0] a, rdv, sd, alu;
    logic [1:0]  sz;
    int op, n;
    for (int i = 0; i < 60; i++) begin
      a   = {$urandom, $urandom};
      sz  = 2'($urandom);
      n   = 1 << sz;
      if ($urandom_range(0, 3) != 0) a[2:0] = 3'((a[2:0] / n) * n);
      rdv = {$urandom, $urandom};
      sd  = {$urandom, $urandom};
      alu = {$urandom, $urandom};
      op  = $urandom_range(0, 2);
      run_op($sformatf("rand%0d", i), alu, a, sd, op == 1, op == 2, sz, 1'($urandom),
             5'($urandom), 1'($urandom), rdv, $urandom_range(0, 2), $urandom_range(0, TO - 1),
             $urandom_range(0, 2), ($urandom_range(0, 9) == 0) && (op != 0));
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_half();
    test_misaligned();
    test_passthrough_hold();
    test_timeout();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
